// File: rtl/debounce_fsmd_pkg.sv
// Shared debouncer types: state encoding and the default timer width.
// Used by debounce_fsmd and its bench.
package debounce_pkg;

  localparam int N_DEF = 21;

  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_WAIT0 = 2'b11;

  typedef enum logic [1:0] {
    ZERO  = ST_ZERO,
    WAIT1 = ST_WAIT1,
    ONE   = ST_ONE,
    WAIT0 = ST_WAIT0
  } state_t;

endpackage

// File: rtl/debounce_fsmd_if.sv
// Switch-side bundle: raw switch in, debounced level and rising tick out.
// master drives sw; slave (the debouncer) drives db_level/db_tick.
interface debounce_fsmd_if;

  logic sw;
  logic db_level;
  logic db_tick;

  modport master (
    output sw,
    input  db_level,
    input  db_tick
  );

  modport slave (
    input  sw,
    output db_level,
    output db_tick
  );

endinterface

// File: rtl/debounce_fsmd_sync_2ff.sv
// One-bit two-flop synchroniser, sync active-high reset to 0.
// Ports: clk, reset, d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_fsmd.sv
// Four-state FSMD switch debouncer with registered level and rising tick.
// Ports: clk, reset (sync, active high), bus (sw in; db_level, db_tick out).
module debounce_fsmd
  import debounce_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            reset,
  debounce_fsmd_if.slave  bus
);

  localparam logic [N-1:0] M      = '1;
  localparam logic [N-1:0] Q_LAST = N'(1);

  logic         sw_s;
  state_t       state, state_nx;
  logic [N-1:0] q, q_nx;
  logic         lvl_r, lvl_nx;
  logic         tick_r, tick_nx;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sw),
    .q     (sw_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ZERO;
      q      <= '0;
      lvl_r  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      state  <= state_nx;
      q      <= q_nx;
      lvl_r  <= lvl_nx;
      tick_r <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q;
    tick_nx  = 1'b0;
    unique case (state)
      ZERO: begin
        if (sw_s) begin
          q_nx     = M;
          state_nx = WAIT1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_nx = ZERO;
        end else if (q == Q_LAST) begin
          q_nx     = '0;
          state_nx = ONE;
          tick_nx  = 1'b1;
        end else begin
          q_nx = q - Q_LAST;
        end
      end
      ONE: begin
        if (!sw_s) begin
          q_nx     = M;
          state_nx = WAIT0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_nx = ONE;
        end else if (q == Q_LAST) begin
          q_nx     = '0;
          state_nx = ZERO;
        end else begin
          q_nx = q - Q_LAST;
        end
      end
      default: begin
        state_nx = ZERO;
      end
    endcase
    // Level follows the stable side the next state belongs to.
    lvl_nx = (state_nx == ONE) || (state_nx == WAIT0);
  end

  assign bus.db_level = lvl_r;
  assign bus.db_tick  = tick_r;

endmodule

// File: tb/tb_debounce_fsmd.sv
// Directed bench for debounce_fsmd (N=3) with a run-length reference
// model feeding a per-cycle scoreboard queue.
module tb_debounce_fsmd;

  localparam int N = 3;
  localparam int M = (1 << N) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  debounce_fsmd_if bus ();

  debounce_fsmd #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic m_s1  = 1'b0;
  logic m_ss  = 1'b0;
  logic m_lvl = 1'b0;
  logic m_tk  = 1'b0;
  int   m_cnt = 0;

  logic [1:0] sb[$];

  int   edge_n   = 0;
  int   rise_at  = -1;
  int   fall_at  = -1;
  int   ticks    = 0;
  int   tick_run = 0;
  int   run_max  = 0;
  logic prev_lvl = 1'b0;

  task automatic check2(input string tag,
                        input logic [1:0] obs,
                        input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d got %b exp %b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag,
                           input int obs,
                           input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic clear();
    edge_n   = 0;
    rise_at  = -1;
    fall_at  = -1;
    ticks    = 0;
    tick_run = 0;
    run_max  = 0;
    prev_lvl = bus.db_level;
  endtask

  // Reference: level flips once the synchronised input has disagreed
  // with it for M+1 consecutive edges.
  task automatic model(input logic s, input logic r);
    if (r) begin
      m_s1  = 1'b0;
      m_ss  = 1'b0;
      m_lvl = 1'b0;
      m_tk  = 1'b0;
      m_cnt = 0;
    end else begin
      m_tk = 1'b0;
      if (m_ss != m_lvl) begin
        m_cnt++;
        if (m_cnt == M + 1) begin
          m_lvl = ~m_lvl;
          m_tk  = m_lvl;
          m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
      m_ss = m_s1;
      m_s1 = s;
    end
  endtask

  task automatic step(input logic s, input logic r);
    logic [1:0] e;
    @(negedge clk);
    bus.sw = s;
    reset  = r;
    @(posedge clk);
    model(s, r);
    sb.push_back({m_lvl, m_tk});
    #1;
    edge_n++;
    e = sb.pop_front();
    check2("out", {bus.db_level, bus.db_tick}, e);
    if (bus.db_tick) begin
      ticks++;
      tick_run++;
      if (tick_run > run_max) run_max = tick_run;
    end else begin
      tick_run = 0;
    end
    if (bus.db_level && !prev_lvl && rise_at < 0) rise_at = edge_n;
    if (!bus.db_level && prev_lvl && fall_at < 0) fall_at = edge_n;
    prev_lvl = bus.db_level;
  endtask

  task automatic hold(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b0);
  endtask

  task automatic do_reset(input logic s, input int n);
    for (int i = 0; i < n; i++) step(s, 1'b1);
  endtask

  initial begin
    logic [5:0] pat;
    bus.sw = 1'b0;
    reset  = 1'b1;

    // Reset with switch held high, then fresh debounce.
    do_reset(1'b1, 3);
    check2("rst_vals", {bus.db_level, bus.db_tick}, 2'b00);
    clear();
    hold(1'b1, 14);
    check_int("rst_rise_edge", rise_at, 10);
    check_int("rst_ticks", ticks, 1);
    check_int("rst_tick_w", run_max, 1);

    // Clean press then release.
    do_reset(1'b0, 2);
    clear();
    hold(1'b1, 20);
    check_int("press_rise_edge", rise_at, 10);
    check_int("press_ticks", ticks, 1);
    clear();
    hold(1'b0, 14);
    check_int("rel_fall_edge", fall_at, 10);
    check_int("rel_ticks", ticks, 0);

    // Bounce on press: 1,0,1,1,0,1 then hold high.
    do_reset(1'b0, 2);
    clear();
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) step(pat[i], 1'b0);
    hold(1'b1, 14);
    check_int("bnc_rise_edge", rise_at, 15);
    check_int("bnc_ticks", ticks, 1);

    // Bounce on release: short low pulse while ONE.
    clear();
    hold(1'b0, 4);
    hold(1'b1, 14);
    check_int("bncrel_fall", fall_at, -1);
    check_int("bncrel_ticks", ticks, 0);
    check2("bncrel_lvl", {bus.db_level, bus.db_tick}, 2'b10);

    // Reset while in WAIT1 with q = 3.
    do_reset(1'b0, 2);
    clear();
    hold(1'b1, 7);
    step(1'b1, 1'b1);
    check2("midrst_vals", {bus.db_level, bus.db_tick}, 2'b00);
    clear();
    hold(1'b1, 12);
    check_int("midrst_rise", rise_at, 10);
    check_int("midrst_ticks", ticks, 1);

    // Five clean presses.
    do_reset(1'b0, 2);
    clear();
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 15);
      hold(1'b0, 15);
    end
    check_int("multi_ticks", ticks, 5);
    check_int("multi_tick_w", run_max, 1);
    check_int("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
